// File: rtl/core_bus_bridge_pkg.sv
// Shared definitions for the Wishbone-to-controller memory bridge:
// FSM state codes, byte-select shorthands and the sub-word merge helper.
package core_bus_bridge_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_READ     = 3'd1;
  localparam logic [2:0] ST_RMW_READ = 3'd2;
  localparam logic [2:0] ST_WRITE    = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;
  localparam logic [2:0] ST_ERR      = 3'd5;

  localparam logic [3:0] SEL_FULL = 4'hF;
  localparam logic [3:0] SEL_NONE = 4'h0;

  // Selected lanes come from the store data, the rest from the word read back.
  function automatic logic [31:0] merge_lanes(input logic [3:0]  sel,
                                              input logic [31:0] new_dat,
                                              input logic [31:0] old_dat);
    logic [31:0] word;
    word = old_dat;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) word[8*i +: 8] = new_dat[8*i +: 8];
    end
    return word;
  endfunction

endpackage

// File: rtl/core_bus_bridge_bus_timeout_counter.sv
// Counts wait cycles of one memory access; expired_o flags that the allowed
// number of wait cycles has been used up. Counting stops once expired.
module bus_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TIMEOUT_BITS   = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [TIMEOUT_BITS-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == TIMEOUT_BITS'(TIMEOUT_CYCLES));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expired_o) begin
      cnt_d = cnt_q + TIMEOUT_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/core_bus_bridge.sv
// Wishbone-classic slave to level-held controller memory requests, with
// read-modify-write for partial stores and a per-access timeout.
module core_bus_bridge
  import core_bus_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TIMEOUT_BITS   = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        ctrl_read_o,
  output logic        ctrl_write_o,
  output logic [31:0] ctrl_address_o,
  output logic [31:0] ctrl_write_data_o,
  input  logic [31:0] ctrl_read_data_i,
  input  logic        ctrl_response_i,
  output logic        busy_o
);

  logic [2:0]  state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic        abort_q, abort_d;
  logic        mem_state;
  logic        expired;

  assign mem_state = (state_q == ST_READ) || (state_q == ST_RMW_READ) || (state_q == ST_WRITE);

  bus_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMEOUT_BITS  (TIMEOUT_BITS)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (state_d != state_q),
    .enable_i (mem_state && !ctrl_response_i),
    .expired_o(expired)
  );

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    sel_d   = sel_q;
    we_d    = we_q;
    abort_d = abort_q;
    case (state_q)
      ST_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          adr_d   = wb_adr_i;
          wdata_d = wb_dat_i;
          sel_d   = wb_sel_i;
          we_d    = wb_we_i;
          abort_d = 1'b0;
          if (!wb_we_i)                  state_d = ST_READ;
          else if (wb_sel_i == SEL_FULL) state_d = ST_WRITE;
          else if (wb_sel_i == SEL_NONE) state_d = ST_DONE;
          else                           state_d = ST_RMW_READ;
        end
      end
      ST_READ, ST_RMW_READ, ST_WRITE: begin
        // Memory cannot cancel, so an abort only changes where the response leads.
        abort_d = abort_q || !wb_cyc_i;
        if (ctrl_response_i) begin
          if (abort_d) begin
            state_d = ST_IDLE;
          end else if (state_q == ST_READ) begin
            rdata_d = ctrl_read_data_i;
            state_d = ST_DONE;
          end else if (state_q == ST_RMW_READ) begin
            wdata_d = merge_lanes(sel_q, wdata_q, ctrl_read_data_i);
            state_d = ST_WRITE;
          end else begin
            state_d = ST_DONE;
          end
        end else if (expired) begin
          state_d = ST_ERR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      adr_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      abort_q <= abort_d;
    end
  end

  assign busy_o            = (state_q != ST_IDLE);
  assign wb_ack_o          = (state_q == ST_DONE);
  assign wb_err_o          = (state_q == ST_ERR) && !abort_q;
  assign wb_dat_o          = (state_q == ST_DONE && !we_q) ? rdata_q : 32'h0;
  assign ctrl_read_o       = (state_q == ST_READ) || (state_q == ST_RMW_READ);
  assign ctrl_write_o      = (state_q == ST_WRITE);
  assign ctrl_address_o    = (state_q == ST_IDLE) ? 32'h0 : (adr_q & ~32'h3);
  assign ctrl_write_data_o = wdata_q;

endmodule
